// File: rtl/disp_scan.sv
// disp_scan: 8-digit multiplexed seven-segment display driver with a sequential
// binary-to-BCD (double-dabble) converter.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   prog_i        frequency program, shown as a decimal digit on the leftmost digit
//   module_sel_i  data source: 1 fibonacci ('F'), 2 timer ('t'), 0/3 none
//   data_valid_i  single-cycle strobe qualifying data_in_i and module_sel_i
//   data_in_i     16-bit unsigned value to display in decimal
//   an_o          digit anodes, active-low, one-hot-low
//   dec_ddp_o     segments {a,b,c,d,e,f,g,dp}, active-low, dp always off
//   conv_busy_o   high while the BCD conversion iterates
//
// Digit layout (k = scan index): 7 prog, 6 source letter, 5 blank, 4..0 value
// (most significant first, leading zeros blanked, units always shown).

module disp_scan #(
    parameter int unsigned SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  prog_i,
    input  logic [1:0]  module_sel_i,
    input  logic        data_valid_i,
    input  logic [15:0] data_in_i,
    output logic [7:0]  an_o,
    output logic [7:0]  dec_ddp_o,
    output logic        conv_busy_o
);

    typedef enum logic [1:0] {StIdle, StConv, StLoad} state_e;

    localparam logic [7:0] SegBlank = 8'hFF;

    state_e               state_q;
    logic                 busy_q;
    // {bcd[19:0], bin[15:0]}; the BCD digits end up in the top 20 bits after 16 shifts
    logic [35:0]          shift_q;
    logic [3:0]           iter_q;
    logic [1:0]           sel_conv_q;
    logic                 pend_v_q;
    logic [15:0]          pend_data_q;
    logic [1:0]           pend_sel_q;
    logic [19:0]          disp_bcd_q;
    logic [1:0]           disp_mod_q;
    logic [SCAN_BITS+2:0] scan_q;
    logic [7:0]           an_q;
    logic [7:0]           seg_q;

    logic [2:0]           digit_idx;
    logic [4:0]           shown;
    logic                 data_on;
    logic [7:0]           code [8];
    logic [7:0]           an_d;
    logic [7:0]           seg_d;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [35:0] dabble_step(input logic [35:0] s);
        logic [35:0] t;
        t = s;
        for (int i = 0; i < 5; i++) begin
            if (t[16 + 4*i +: 4] >= 4'd5) begin
                t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[34:0], 1'b0};
    endfunction

    function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Conversion FSM. A strobe arriving while busy parks in the one-deep pending
    // slot (last-wins) and is started straight out of LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            shift_q     <= '0;
            iter_q      <= '0;
            sel_conv_q  <= '0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            pend_sel_q  <= '0;
            disp_bcd_q  <= '0;
            disp_mod_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (data_valid_i) begin
                        shift_q    <= {20'd0, data_in_i};
                        sel_conv_q <= module_sel_i;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    shift_q <= dabble_step(shift_q);
                    iter_q  <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        busy_q  <= 1'b0;
                        state_q <= StLoad;
                    end
                    if (data_valid_i) begin
                        pend_v_q    <= 1'b1;
                        pend_data_q <= data_in_i;
                        pend_sel_q  <= module_sel_i;
                    end
                end
                StLoad: begin
                    disp_bcd_q <= shift_q[35:16];
                    disp_mod_q <= sel_conv_q;
                    iter_q     <= '0;
                    if (pend_v_q) begin
                        shift_q    <= {20'd0, pend_data_q};
                        sel_conv_q <= pend_sel_q;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                        // A strobe in this same cycle becomes the next pending sample.
                        pend_v_q   <= data_valid_i;
                        if (data_valid_i) begin
                            pend_data_q <= data_in_i;
                            pend_sel_q  <= module_sel_i;
                        end
                    end else if (data_valid_i) begin
                        shift_q    <= {20'd0, data_in_i};
                        sel_conv_q <= module_sel_i;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Segment selection for the digit addressed by the scan counter.
    always_comb begin
        digit_idx = scan_q[SCAN_BITS+2:SCAN_BITS];
        data_on   = (disp_mod_q == 2'd1) || (disp_mod_q == 2'd2);

        // A digit is lit if it or any more significant digit is nonzero.
        shown[4] = (disp_bcd_q[19:16] != 4'd0);
        shown[3] = shown[4] || (disp_bcd_q[15:12] != 4'd0);
        shown[2] = shown[3] || (disp_bcd_q[11:8] != 4'd0);
        shown[1] = shown[2] || (disp_bcd_q[7:4] != 4'd0);
        shown[0] = 1'b1;

        for (int i = 0; i < 5; i++) begin
            code[i] = (data_on && shown[i]) ? seg_of_digit(disp_bcd_q[4*i +: 4]) : SegBlank;
        end
        code[5] = SegBlank;
        case (disp_mod_q)
            2'd1:    code[6] = 8'h71;
            2'd2:    code[6] = 8'hE1;
            default: code[6] = SegBlank;
        endcase
        code[7] = seg_of_digit({1'b0, prog_i});

        an_d  = ~(8'd1 << digit_idx);
        seg_d = code[digit_idx];
    end

    // Scan counter and registered anode/segment outputs, updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            an_q   <= 8'hFF;
            seg_q  <= SegBlank;
        end else begin
            scan_q <= scan_q + 1'b1;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an_o        = an_q;
    assign dec_ddp_o   = seg_q;
    assign conv_busy_o = busy_q;

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan with SCAN_BITS=2. A transaction-level model
// tracks which value is displayed when (strobe cycle N -> shown from N+18) and
// derives expected segments from the decimal value with plain arithmetic.

module tb_disp_scan;

    localparam int unsigned SB = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  prog;
    logic [1:0]  module_sel;
    logic        data_valid;
    logic [15:0] data_in;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;
    logic        conv_busy;

    always #5 clk = ~clk;

    disp_scan #(
        .SCAN_BITS(SB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_i      (prog),
        .module_sel_i(module_sel),
        .data_valid_i(data_valid),
        .data_in_i   (data_in),
        .an_o        (an),
        .dec_ddp_o   (dec_ddp),
        .conv_busy_o (conv_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int t        = 0;

    // Reference model state.
    bit act;
    int act_n, act_val, act_sel;
    bit pend;
    int pend_val, pend_sel;
    int disp_val, disp_sel;

    logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 30) begin
                $display("FAIL %s: got %h expected %h (cycle %0d after reset)", tag, got, exp, t);
            end
        end
    endtask

    function automatic logic [7:0] exp_seg(input int k, input int v, input int m, input int p);
        int pw;
        if (k == 7) return seg_tab[p];
        if (k == 6) return (m == 1) ? 8'h71 : ((m == 2) ? 8'hE1 : 8'hFF);
        if (k == 5) return 8'hFF;
        if (m != 1 && m != 2) return 8'hFF;
        pw = 1;
        for (int i = 0; i < k; i++) pw = pw * 10;
        if (k != 0 && v < pw) return 8'hFF;
        return seg_tab[(v / pw) % 10];
    endfunction

    // Advance the model by cycle t with that cycle's inputs.
    task automatic model_step(input bit dv, input int d, input int sel);
        if (act && t == act_n + 17) begin
            disp_val = act_val;
            disp_sel = act_sel;
            if (pend) begin
                act_val = pend_val;
                act_sel = pend_sel;
                act_n   = t;
                pend    = dv;
                pend_val = d;
                pend_sel = sel;
            end else if (dv) begin
                act_val = d;
                act_sel = sel;
                act_n   = t;
            end else begin
                act = 1'b0;
            end
        end else if (act) begin
            if (dv) begin
                pend     = 1'b1;
                pend_val = d;
                pend_sel = sel;
            end
        end else if (dv) begin
            act     = 1'b1;
            act_val = d;
            act_sel = sel;
            act_n   = t;
        end
    endtask

    task automatic step(input bit dv, input int d, input int sel);
        int         sv, sm, sp, k;
        logic [7:0] an_exp;
        bit         busy_exp;
        data_valid = dv;
        data_in    = d[15:0];
        module_sel = sel[1:0];
        sv = disp_val;
        sm = disp_sel;
        sp = int'(prog);
        k  = (t >> SB) & 7;
        model_step(dv, d, sel);
        @(posedge clk);
        #1;
        t++;
        an_exp   = ~(8'd1 << k);
        busy_exp = act && (t >= act_n + 1) && (t <= act_n + 16);
        check("an", {24'd0, an}, {24'd0, an_exp});
        check("dec_ddp", {24'd0, dec_ddp}, {24'd0, exp_seg(k, sv, sm, sp)});
        check("conv_busy", {31'd0, conv_busy}, {31'd0, busy_exp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_an", {24'd0, an}, 32'hFF);
            check("rst_dec_ddp", {24'd0, dec_ddp}, 32'hFF);
            check("rst_conv_busy", {31'd0, conv_busy}, 32'd0);
        end
        rst      = 1'b0;
        t        = 0;
        act      = 1'b0;
        pend     = 1'b0;
        disp_val = 0;
        disp_sel = 0;
    endtask

    initial begin
        int d, sel;
        bit dv;
        rst        = 1'b1;
        prog       = 3'd5;
        module_sel = 2'd0;
        data_valid = 1'b0;
        data_in    = 16'd0;

        // Idle scan after reset: anode walk with prog on the leftmost digit.
        do_reset();
        idle(40);

        // Full-scale value from the fibonacci source.
        step(1'b1, 65535, 1);
        idle(60);

        // Small value from the timer: leading zeros blanked.
        step(1'b1, 7, 2);
        idle(60);

        // Overlapping strobes: the middle one is overwritten while pending.
        step(1'b1, 100, 1);
        idle(4);
        step(1'b1, 200, 1);
        idle(3);
        step(1'b1, 300, 1);
        idle(60);

        // Reset in the middle of a conversion, then a zero value.
        step(1'b1, 12345, 1);
        idle(7);
        do_reset();
        idle(40);
        step(1'b1, 0, 1);
        idle(60);

        // Random traffic, including back-to-back strobes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) prog = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) do_reset();
            dv  = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       d = $urandom_range(0, 9);
                1:       d = $urandom_range(0, 999);
                2:       d = $urandom_range(0, 65535);
                default: d = ($urandom_range(0, 1) == 1) ? 65535 : 0;
            endcase
            step(dv, d, sel);
        end
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter SCAN_BITS, default 17, sets digit dwell to 2^SCAN_BITS clk cycles.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 prog  input  3  current frequency program, displayed as a decimal digit 0-7.
REQ-005 module_sel  input  2  data source: 0 none, 1 fibonacci, 2 timer, 3 reserved (treated as 0).
REQ-006 data_valid  input  1  single-cycle strobe qualifying data_in.
REQ-007 data_in  input  16  unsigned binary value from the buffer read side.
REQ-008 an  output  8  digit anodes, active-low, one-hot-low.
REQ-009 dec_ddp  output  8  segments {a,b,c,d,e,f,g,dp}, active-low; dec_ddp[0]=dp.
REQ-010 conv_busy  output  1  high while the BCD conversion runs.

Function
REQ-011 Capture: when data_valid=1 in cycle N, data_in and module_sel are registered; conversion begins in cycle N+1.
REQ-012 Conversion: sequential double-dabble, 16 shift iterations in cycles N+1..N+16, producing 5 BCD digits; add-3 to any nibble >=5 before each shift.
REQ-013 Display registers (5 BCD digits plus module code) update at the end of cycle N+17; conv_busy is high in cycles N+1..N+16 only.
REQ-014 FSM states: IDLE, CONV, LOAD. IDLE->CONV on a pending capture; CONV->LOAD after iteration 16; LOAD->IDLE, or LOAD->CONV when another capture is pending.
REQ-015 data_valid during CONV or LOAD is stored in a one-deep pending register, last-wins; it is converted immediately after the current LOAD, and no valid sample is lost except overwritten pending ones.
REQ-016 Scan counter of width SCAN_BITS+3 increments every cycle and wraps; digit index k = counter[SCAN_BITS+2:SCAN_BITS]; an[k]=0 and all other anodes are 1.
REQ-017 Digit map: k=7 shows prog; k=6 shows the module letter ('F' 8'h71 for 1, 't' 8'hE1 for 2, blank otherwise); k=5 is blank; k=4..0 show BCD digits most-significant first, so k=0 is the units digit.
REQ-018 Leading-zero blanking: any BCD digit above the most significant nonzero digit is blank; the units digit is always shown, so value 0 displays "0".
REQ-019 When the displayed module code is 0 or 3, digits k=4..0 are blank.
REQ-020 Segment codes (dp off): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09; blank=FF (hex).
REQ-021 The dp segment is always off (dec_ddp[0]=1).
REQ-022 an and dec_ddp are registered and change together: the segment code matches the anode driven in the same cycle.

Reset
REQ-023 While rst=1, the following hold: an=8'hFF, dec_ddp=8'hFF, conv_busy=0, scan counter=0, FSM=IDLE, pending cleared, BCD digits=0, module code=0.
REQ-024 rst asserted mid-conversion aborts it; the display registers take reset values and the aborted value is never shown.
REQ-025 In the first cycle after rst deasserts, an=8'hFE with the k=0 code shown (blank, since module code=0).

Verification
REQ-026 SCAN_BITS=2; after reset with no data: an cycles FE,FD,FB,...,7F, each held 4 cycles; k=7 shows prog=5 as 8'h49; all other digits FF.
REQ-027 module_sel=1, data_in=16'd65535, strobe at N: conv_busy high N+1..N+16; from N+18, k=4..0 show 6,5,5,3,5 (41,49,49,0D,49); k=6 shows 71.
REQ-028 module_sel=2, data_in=16'd7: k=0 shows 1F; k=1..4 show FF; k=6 shows E1.
REQ-029 Strobes with 100 at N, 200 at N+5, and 300 at N+9: 100 is displayed, then 300; 200 is never displayed.
REQ-030 rst pulse at N+8 during conversion of 12345: all outputs take reset values; after release, blank data digits; a subsequent strobe of 0 shows "0" (03) at k=0.
